// File: rtl/sim_dump_ctrl_if.sv
// sim_dump_ctrl_if: DMEM read port and dump word stream between sim_dump_ctrl and its consumer
interface sim_dump_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              rd_en;
  logic [0:ADDR_W-1] rd_addr;
  logic [0:DATA_W-1] rd_data;
  logic              dump_valid;
  logic              dump_ready;
  logic [0:ADDR_W-1] dump_addr;
  logic [0:DATA_W-1] dump_data;
  logic              dump_last;
  modport master (
    output rd_en, rd_addr, dump_valid, dump_addr, dump_data, dump_last,
    input  rd_data, dump_ready
  );
  modport slave (
    input  rd_en, rd_addr, dump_valid, dump_addr, dump_data, dump_last,
    output rd_data, dump_ready
  );
endinterface

// File: rtl/sim_dump_ctrl.sv
// sim_dump_ctrl: program-end detector and DMEM dump sequencer; defining SIM_DUMP_HALT_ON_X_EN also halts on X/Z fetches
module sim_dump_ctrl #(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [0:ADDR_W-1] DUMP_BASE    = 8192,
  parameter int unsigned       DUMP_LEN     = 100,
  parameter logic [0:ADDR_W-1] STRIDE       = 1,
  parameter int unsigned       DRAIN_CYCLES = 4,
  parameter logic [0:31]       HALT_INSTR   = 32'hFFFF_FFFF,
  parameter logic [0:31]       MAX_CYCLES   = 0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [0:31]     instr,
  sim_dump_ctrl_if.master bus,
  output logic            done,
  output logic            timed_out,
  output logic [0:31]     cycle_count
);
  typedef enum logic [2:0] {RUN, DRAIN, READ, WAIT, EMIT, DONE} state_t;
  state_t      state;
  logic [31:0] idx;
  logic [31:0] drain_cnt;
  logic        halt;
  logic        wd;
  logic        last;
`ifdef SIM_DUMP_HALT_ON_X_EN
  assign halt = (instr == HALT_INSTR) || (^instr === 1'bx);
`else
  assign halt = instr == HALT_INSTR;
`endif
  assign wd   = (MAX_CYCLES != 0) && (cycle_count == MAX_CYCLES - 32'd1);
  assign last = idx == DUMP_LEN - 32'd1;
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= RUN;
      idx            <= '0;
      drain_cnt      <= '0;
      cycle_count    <= '0;
      done           <= 1'b0;
      timed_out      <= 1'b0;
      bus.rd_en      <= 1'b0;
      bus.rd_addr    <= '0;
      bus.dump_valid <= 1'b0;
      bus.dump_addr  <= '0;
      bus.dump_data  <= {DATA_W{1'b0}};
      bus.dump_last  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (~&cycle_count) cycle_count <= cycle_count + 32'd1;
          if (halt || wd) begin
            // a zero-length drain skips DRAIN so the first read still lands DRAIN_CYCLES+1 cycles after termination
            state       <= DRAIN_CYCLES == 0 ? READ : DRAIN;
            bus.rd_en   <= DRAIN_CYCLES == 0;
            bus.rd_addr <= DUMP_BASE;
            drain_cnt   <= '0;
            timed_out   <= wd && !halt;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_CYCLES - 32'd1) begin
            state     <= READ;
            bus.rd_en <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 32'd1;
          end
        end
        READ: begin
          bus.rd_en <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          bus.dump_valid <= 1'b1;
          bus.dump_addr  <= bus.rd_addr;
          bus.dump_data  <= bus.rd_data;
          bus.dump_last  <= last;
          state          <= EMIT;
        end
        EMIT: begin
          if (bus.dump_ready) begin
            bus.dump_valid <= 1'b0;
            bus.dump_last  <= 1'b0;
            if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              idx         <= idx + 32'd1;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= bus.rd_addr + STRIDE;
              state       <= READ;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sim_dump_ctrl.sv
// tb_sim_dump_ctrl: directed table-driven checks of sim_dump_ctrl plus hand-written multi-cycle sequences
module tb_sim_dump_ctrl;
  localparam logic [0:31] HALT = 32'hFFFF_FFFF;
  localparam logic [0:31] BA   = 32'd8192;
  localparam logic        H    = 1'b1;
  localparam logic        L    = 1'b0;
  typedef struct {
    logic        ready;
    logic        rd_en;
    logic [0:31] rd_addr;
    logic        valid;
    logic [0:31] addr;
    logic        last;
    logic        done;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] instr_a = '0;
  logic [0:31] instr_b = '0;
  logic        done_a, to_a, done_b, to_b;
  logic [0:31] cnt_a, cnt_b;
  int          tests = 0;
  int          fails = 0;
  vec_t        tbl [14];
  sim_dump_ctrl_if bus_a ();
  sim_dump_ctrl_if bus_b ();
  sim_dump_ctrl #(.DUMP_BASE(BA), .DUMP_LEN(3), .STRIDE(1), .DRAIN_CYCLES(4), .MAX_CYCLES(20)) u_a (
    .clock(clk), .reset(rst), .instr(instr_a), .bus(bus_a),
    .done(done_a), .timed_out(to_a), .cycle_count(cnt_a)
  );
  sim_dump_ctrl #(.DUMP_BASE(32'hFFFF_FFFE), .DUMP_LEN(4), .STRIDE(1), .DRAIN_CYCLES(4), .MAX_CYCLES(0)) u_b (
    .clock(clk), .reset(rst), .instr(instr_b), .bus(bus_b),
    .done(done_b), .timed_out(to_b), .cycle_count(cnt_b)
  );
  always #5 clk = ~clk;
  function automatic logic [0:31] mem(input logic [0:31] a);
    return {a[16:31], a[0:15]} ^ 32'hC3C3_0000;
  endfunction
  // DMEM model: one-cycle read latency, garbage when not strobed
  always @(posedge clk) begin
    bus_a.rd_data <= bus_a.rd_en ? mem(bus_a.rd_addr) : 32'hDEAD_BEEF;
    bus_b.rd_data <= bus_b.rd_en ? mem(bus_b.rd_addr) : 32'hDEAD_BEEF;
  end
  function automatic vec_t v(input logic r, input logic e, input logic [0:31] ra,
                             input logic vl, input logic [0:31] a, input logic l, input logic d);
    return '{ready: r, rd_en: e, rd_addr: ra, valid: vl, addr: a, last: l, done: d};
  endfunction
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic reset_all();
    rst = 1'b1;
    instr_a = '0;
    instr_b = '0;
    bus_a.dump_ready = 1'b0;
    bus_b.dump_ready = 1'b0;
    step(2);
    rst = 1'b0;
  endtask
  task automatic check_zero(input string tag);
    check({tag, " strobes"}, 128'({bus_a.rd_en, bus_a.dump_valid, bus_a.dump_last, done_a, to_a}), 128'(0));
    check({tag, " addrs"}, 128'({bus_a.rd_addr, bus_a.dump_addr}), 128'(0));
    check({tag, " data/count"}, 128'({bus_a.dump_data, cnt_a}), 128'(0));
  endtask
  task automatic wait_valid_a(input int lim);
    for (int i = 0; i < lim && !bus_a.dump_valid; i++) step(1);
    check("wait dump_valid", 128'(bus_a.dump_valid), 128'(1));
  endtask
  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1);
  end
  initial begin
    logic [0:31] wa [4];
    logic [0:31] wdat [4];
    logic        wl [4];
    logic [0:31] exp_wa [4];
    int          n;
    bit          found;
    tbl[0]  = v(H, L, '0,        L, '0,        L, L);
    tbl[1]  = v(H, L, '0,        L, '0,        L, L);
    tbl[2]  = v(H, L, '0,        L, '0,        L, L);
    tbl[3]  = v(H, H, BA,        L, '0,        L, L);
    tbl[4]  = v(H, L, '0,        L, '0,        L, L);
    tbl[5]  = v(H, L, '0,        H, BA,        L, L);
    tbl[6]  = v(H, H, BA + 1,    L, '0,        L, L);
    tbl[7]  = v(H, L, '0,        L, '0,        L, L);
    tbl[8]  = v(H, L, '0,        H, BA + 1,    L, L);
    tbl[9]  = v(H, H, BA + 2,    L, '0,        L, L);
    tbl[10] = v(H, L, '0,        L, '0,        L, L);
    tbl[11] = v(H, L, '0,        H, BA + 2,    H, L);
    tbl[12] = v(H, L, '0,        L, '0,        L, H);
    tbl[13] = v(H, L, '0,        L, '0,        L, H);
    exp_wa = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    // halt at cycle 10, full dump with ready held high
    reset_all();
    check_zero("reset");
    step(9);
    instr_a = HALT;
    step(1);
    instr_a = 32'h1234_5678;
    check("halt cycle_count", 128'(cnt_a), 128'(10));
    for (int i = 0; i < 14; i++) begin
      bus_a.dump_ready = tbl[i].ready;
      step(1);
      check($sformatf("seq row %0d", i),
        128'({bus_a.rd_en, tbl[i].rd_en ? bus_a.rd_addr : 32'h0, bus_a.dump_valid,
              tbl[i].valid ? bus_a.dump_addr : 32'h0, tbl[i].valid ? bus_a.dump_data : 32'h0,
              bus_a.dump_last, done_a}),
        128'({tbl[i].rd_en, tbl[i].rd_addr, tbl[i].valid, tbl[i].addr,
              tbl[i].valid ? mem(tbl[i].addr) : 32'h0, tbl[i].last, tbl[i].done}));
    end
    check("frozen count/timed_out", 128'({cnt_a, to_a}), 128'({32'd10, 1'b0}));
    // back-pressure on the first word
    reset_all();
    instr_a = HALT;
    step(1);
    instr_a = '0;
    wait_valid_a(20);
    for (int i = 0; i < 7; i++) begin
      step(1);
      check($sformatf("backpressure hold %0d", i),
        128'({bus_a.dump_valid, bus_a.dump_addr, bus_a.dump_data, bus_a.rd_en}),
        128'({1'b1, BA, mem(BA), 1'b0}));
    end
    bus_a.dump_ready = 1'b1;
    step(1);
    check("backpressure release", 128'({bus_a.rd_en, bus_a.rd_addr, bus_a.dump_valid}),
          128'({1'b1, BA + 32'd1, 1'b0}));
    // watchdog alone
    reset_all();
    step(19);
    check("wd before", 128'({cnt_a, to_a}), 128'({32'd19, 1'b0}));
    step(1);
    check("wd fire", 128'({cnt_a, to_a}), 128'({32'd20, 1'b1}));
    step(3);
    check("wd drain", 128'({cnt_a, bus_a.rd_en}), 128'({32'd20, 1'b0}));
    step(1);
    check("wd first read", 128'({bus_a.rd_en, bus_a.rd_addr}), 128'({1'b1, BA}));
    // halt and watchdog in the same cycle
    reset_all();
    step(19);
    instr_a = HALT;
    step(1);
    instr_a = '0;
    check("halt+wd", 128'({cnt_a, to_a}), 128'({32'd20, 1'b0}));
    step(4);
    check("halt+wd read", 128'(bus_a.rd_en), 128'(1));
    // address wrap on the second instance
    reset_all();
    instr_b = HALT;
    step(1);
    instr_b = '0;
    bus_b.dump_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      if (bus_b.dump_valid) begin
        wa[n] = bus_b.dump_addr;
        wdat[n] = bus_b.dump_data;
        wl[n] = bus_b.dump_last;
        n++;
      end
      step(1);
    end
    check("wrap word count", 128'(n), 128'(4));
    for (int i = 0; i < n && i < 4; i++)
      check($sformatf("wrap word %0d", i), 128'({wa[i], wdat[i], wl[i]}),
            128'({exp_wa[i], mem(exp_wa[i]), i == 3}));
    check("wrap done", 128'({done_b, to_b, cnt_b}), 128'({1'b1, 1'b0, 32'd1}));
    // reset while the second word is presented
    reset_all();
    instr_a = HALT;
    step(1);
    instr_a = '0;
    bus_a.dump_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (bus_a.dump_valid && bus_a.dump_addr == BA + 32'd1) found = 1'b1;
      else step(1);
    end
    check("reach word 2", 128'(found), 128'(1));
    bus_a.dump_ready = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_zero("mid-emit reset");
    step(3);
    check("rerun counting", 128'(cnt_a), 128'(3));
    instr_a = HALT;
    step(1);
    instr_a = '0;
    wait_valid_a(20);
    check("redump base", 128'({bus_a.dump_addr, bus_a.dump_data}), 128'({BA, mem(BA)}));
    // all-X fetch
    reset_all();
    instr_a = 'x;
    step(10);
    instr_a = '0;
`ifdef SIM_DUMP_HALT_ON_X_EN
    check("x fetch halts", 128'(cnt_a), 128'(1));
`else
    check("x fetch ignored", 128'({cnt_a, bus_a.rd_en}), 128'({32'd10, 1'b0}));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sim_dump_ctrl.md
# sim_dump_ctrl

Program-end detector and memory dump sequencer for processor benches. Watches the instruction stream, detects program termination (halt opcode, watchdog timeout, or optionally an all-X fetch), waits a programmable drain interval so in-flight multi-cycle stores retire, then walks a configurable DMEM window through a synchronous read port and streams each word out over a valid/ready interface. Sits beside `processor`, `imem` and `dmem` in the bench, replacing ad-hoc end-of-run loops with one reusable, parametrised block.

## Interface
- `ADDR_W`, 32, width of the DMEM byte address.
- `DATA_W`, 32, width of a dump word.
- `DUMP_BASE`, 8192, first byte address dumped.
- `DUMP_LEN`, 100, number of words dumped; must be ≥1.
- `STRIDE`, 1, byte increment between consecutive dump addresses.
- `DRAIN_CYCLES`, 4, cycles waited after termination before the first read; 0 allowed.
- `HALT_INSTR`, 32'hFFFF_FFFF, instruction word treated as halt.
- `MAX_CYCLES`, 0, watchdog limit in RUN cycles; 0 disables the watchdog.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr` in [0:31]: instruction currently fetched by the processor.
- `rd_en` out 1: DMEM read strobe.
- `rd_addr` out [0:ADDR_W-1]: DMEM read byte address.
- `rd_data` in [0:DATA_W-1]: read data, valid the cycle after `rd_en`.
- `dump_valid` out 1: dump word available.
- `dump_ready` in 1: consumer accepts the word.
- `dump_addr` out [0:ADDR_W-1]: address of the presented word.
- `dump_data` out [0:DATA_W-1]: presented word.
- `dump_last` out 1: presented word is the final one.
- `done` out 1: dump complete; sticky until reset.
- `timed_out` out 1: termination caused by the watchdog; sticky until reset.
- `cycle_count` out [0:31]: RUN cycles elapsed; saturates at all-ones.

## Operation
- States: RUN, DRAIN, READ, WAIT, EMIT, DONE.
- RUN: `cycle_count` increments each cycle. `instr == HALT_INSTR` goes to DRAIN. If `MAX_CYCLES != 0` and `cycle_count == MAX_CYCLES-1`, goes to DRAIN and sets `timed_out`. When halt and timeout occur in the same cycle, halt wins and `timed_out` stays 0.
- DRAIN: counts `DRAIN_CYCLES` cycles, then goes to READ. With `DRAIN_CYCLES == 0`, goes to READ on the next edge. `instr` is ignored from DRAIN onwards.
- READ: asserts `rd_en` for one cycle with `rd_addr = DUMP_BASE + idx*STRIDE` (modulo 2^ADDR_W, wrap allowed), then goes to WAIT.
- WAIT: captures `rd_data` into the output register, then goes to EMIT.
- EMIT: holds `dump_valid`, `dump_addr`, `dump_data` and `dump_last` (= `idx == DUMP_LEN-1`) stable until `dump_ready`. On the handshake, goes to DONE if last; otherwise increments `idx` and goes to READ.
- DONE: `done = 1`, all strobes 0, remains here until reset.
- `cycle_count` freezes on leaving RUN.

## Timing
- Reset: state RUN, `idx = 0`, `cycle_count = 0`. Every output is 0.
- Reset asserted in any state, including mid-EMIT: the next edge returns the block to the reset state. Any pending word is discarded with no handshake.
- Termination to first `rd_en`: `DRAIN_CYCLES + 1` cycles.
- Per word: 3 cycles (READ, WAIT, EMIT) when `dump_ready` is held high. Back-pressure extends EMIT indefinitely.
- `dump_valid` is never deasserted without a handshake. `rd_en` is never asserted outside READ.
- `dump_ready` arriving while `dump_valid` is low has no effect.

## Configuration
- `SIM_DUMP_HALT_ON_X_EN` defined: in RUN, `^instr === 1'bx` (any X/Z bit) is also treated as halt, with the same priority as a `HALT_INSTR` match. This is simulation-only logic.
- Undefined: only `HALT_INSTR` and the watchdog terminate RUN. The block is fully synthesizable.

## Test plan
- Halt at cycle 10 with `DRAIN_CYCLES=4`, `DUMP_LEN=3`, `dump_ready=1`: first `rd_en` 5 cycles after halt. Addresses 8192, 8193, 8194 are presented with the preloaded data. `dump_last` is set on the third word only. `done` is set 1 cycle after the last handshake. `cycle_count=10`.
- Back-pressure: `dump_ready` low for 7 cycles during EMIT. `dump_valid`, `dump_addr` and `dump_data` stay stable, and no `rd_en` is issued until the handshake.
- Watchdog: `MAX_CYCLES=20`, no halt. Block enters DRAIN after 20 RUN cycles with `timed_out=1` and `cycle_count=20`. Halt and timeout in the same cycle: `timed_out=0`.
- Wrap: `DUMP_BASE=32'hFFFF_FFFE`, `STRIDE=1`, `DUMP_LEN=4`. Addresses are FFFF_FFFE, FFFF_FFFF, 0, 1.
- Reset asserted mid-EMIT on word 2: the next cycle shows all outputs 0 and state RUN. A subsequent halt re-dumps from `DUMP_BASE`.
- With `SIM_DUMP_HALT_ON_X_EN`: `instr = 32'hxxxx_xxxx` triggers DRAIN. Without the macro, the same stimulus keeps the block in RUN.
